// File: rtl/video_pkg.sv
// Shared video definitions: default raster geometry, the timing bundle carried
// down the output pipeline, and a helper to derive line/frame totals.
package video_pkg;

  localparam int NTSC_ACTIVE_H = 256;
  localparam int NTSC_FRONT_H  = 9;
  localparam int NTSC_SYNC_H   = 51;
  localparam int NTSC_BACK_H   = 25;
  localparam int NTSC_ACTIVE_V = 240;
  localparam int NTSC_FRONT_V  = 5;
  localparam int NTSC_SYNC_V   = 1;
  localparam int NTSC_BACK_V   = 16;

  localparam int MAX_PIPE_DELAY = 15;

  // Internal, active-high view of the raster; polarity is applied at the pins.
  typedef struct packed {
    logic hsync;
    logic vsync;
    logic active;
    logic frame_start;
  } timing_t;

  function automatic int total_span(input int active, input int front,
                                    input int sync, input int back);
    return active + front + sync + back;
  endfunction

endpackage

// File: rtl/video_delay_line.sv
// Clock-enabled shift register of configurable depth and width, clearing to a
// fixed idle value; DEPTH = 0 is a plain wire.
module video_delay_line #(
  parameter int               DEPTH       = 2,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] delayed
);

  if (DEPTH == 0) begin : g_pass
    assign delayed = data;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        // NOTE: this array is cleared on reset because it is a handful of flops
        // whose contents reach the pins; large data buffers would be left unreset.
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= CLEAR_VALUE;
      end else if (enable) begin
        // NOTE: non-blocking assignments make every stage sample its neighbour's
        // pre-edge value, so the order of these statements does not matter.
        stage_q[0] <= data;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign delayed = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/video_timing.sv
// Raster timing generator: x/y counters with registered early decode, plus
// sync/de/frame strobes delayed to match the downstream pixel pipeline.
module video_timing
  import video_pkg::*;
#(
  parameter int ACTIVE_H   = NTSC_ACTIVE_H,
  parameter int FRONT_H    = NTSC_FRONT_H,
  parameter int SYNC_H     = NTSC_SYNC_H,
  parameter int BACK_H     = NTSC_BACK_H,
  parameter int ACTIVE_V   = NTSC_ACTIVE_V,
  parameter int FRONT_V    = NTSC_FRONT_V,
  parameter int SYNC_V     = NTSC_SYNC_V,
  parameter int BACK_V     = NTSC_BACK_V,
  parameter bit HSYNC_POL  = 1'b0,
  parameter bit VSYNC_POL  = 1'b0,
  parameter int PIPE_DELAY = 2,
  parameter int COORD_W    = 10
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  output logic [COORD_W-1:0] out_x,
  output logic [COORD_W-1:0] out_y,
  output logic               out_active,
  output logic               out_line_start,
  output logic               out_frame_start,
  output logic               out_hsync,
  output logic               out_vsync,
  output logic               out_de,
  output logic               out_frame_start_d
);

  localparam int TOTAL_H = total_span(ACTIVE_H, FRONT_H, SYNC_H, BACK_H);
  localparam int TOTAL_V = total_span(ACTIVE_V, FRONT_V, SYNC_V, BACK_V);

  if (TOTAL_H > (1 << COORD_W) || TOTAL_V > (1 << COORD_W) ||
      SYNC_H == 0 || SYNC_V == 0 ||
      PIPE_DELAY < 0 || PIPE_DELAY > MAX_PIPE_DELAY) begin : g_bad_config
    $error("video_timing: geometry does not fit COORD_W, zero sync width, or PIPE_DELAY out of range");
  end

  localparam logic [COORD_W-1:0] X_LAST = COORD_W'(TOTAL_H - 1);
  localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(TOTAL_V - 1);

  function automatic timing_t decode(input logic [COORD_W-1:0] x,
                                     input logic [COORD_W-1:0] y);
    int      xi;
    int      yi;
    timing_t t;
    xi            = int'(x);
    yi            = int'(y);
    t.active      = (xi < ACTIVE_H) && (yi < ACTIVE_V);
    t.hsync       = (xi >= ACTIVE_H + FRONT_H) && (xi < ACTIVE_H + FRONT_H + SYNC_H);
    t.vsync       = (yi >= ACTIVE_V + FRONT_V) && (yi < ACTIVE_V + FRONT_V + SYNC_V);
    t.frame_start = (xi == 0) && (yi == 0);
    return t;
  endfunction

  localparam timing_t RESET_EARLY = decode('0, '0);

  logic [COORD_W-1:0] x_q, y_q, x_n, y_n;
  logic               line_start_q;
  timing_t            early_q;
  timing_t            delayed;

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch forms.
    x_n = x_q + COORD_W'(1);
    y_n = y_q;
    if (x_q == X_LAST) begin
      x_n = '0;
      y_n = (y_q == Y_LAST) ? '0 : y_q + COORD_W'(1);
    end
  end

  // Early outputs decode the counters' next value so they move with out_x/out_y.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_q          <= '0;
      y_q          <= '0;
      early_q      <= RESET_EARLY;
      line_start_q <= 1'b1;
    end else if (enable) begin
      x_q          <= x_n;
      y_q          <= y_n;
      early_q      <= decode(x_n, y_n);
      line_start_q <= (x_n == '0);
    end
  end

  video_delay_line #(
    .DEPTH       (PIPE_DELAY),
    .WIDTH       ($bits(timing_t)),
    .CLEAR_VALUE ('0)
  ) u_delay (
    .clock   (clock),
    .reset   (reset),
    .enable  (enable),
    .data    (early_q),
    .delayed (delayed)
  );

  assign out_x             = x_q;
  assign out_y             = y_q;
  assign out_active        = early_q.active;
  assign out_line_start    = line_start_q;
  assign out_frame_start   = early_q.frame_start;
  assign out_hsync         = HSYNC_POL ? delayed.hsync : ~delayed.hsync;
  assign out_vsync         = VSYNC_POL ? delayed.vsync : ~delayed.vsync;
  assign out_de            = delayed.active;
  assign out_frame_start_d = delayed.frame_start;

endmodule

// File: tb/tb_video_timing.sv
// Bench for video_timing: two instances (delay 2 / active-low syncs, delay 0 /
// active-high syncs) compared every cycle against a position-based raster model.
`timescale 1ns/1ps
module tb_video_timing;

  localparam int AH = 4, FH = 1, SH = 2, BH = 1;
  localparam int AV = 3, FV = 1, SV = 1, BV = 1;
  localparam int TH = AH + FH + SH + BH;
  localparam int TV = AV + FV + SV + BV;
  localparam int FRAME = TH * TV;
  localparam int DELAY_A = 2;
  localparam int DELAY_B = 0;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic enable = 1'b0;

  logic [9:0] a_x, a_y, b_x, b_y;
  logic a_active, a_line_start, a_frame_start, a_hsync, a_vsync, a_de, a_frame_start_d;
  logic b_active, b_line_start, b_frame_start, b_hsync, b_vsync, b_de, b_frame_start_d;

  always #5 clock = ~clock;

  video_timing #(
    .ACTIVE_H(AH), .FRONT_H(FH), .SYNC_H(SH), .BACK_H(BH),
    .ACTIVE_V(AV), .FRONT_V(FV), .SYNC_V(SV), .BACK_V(BV),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .PIPE_DELAY(DELAY_A), .COORD_W(10)
  ) dut_a (
    .clock(clock), .reset(reset), .enable(enable),
    .out_x(a_x), .out_y(a_y), .out_active(a_active), .out_line_start(a_line_start),
    .out_frame_start(a_frame_start), .out_hsync(a_hsync), .out_vsync(a_vsync),
    .out_de(a_de), .out_frame_start_d(a_frame_start_d)
  );

  video_timing #(
    .ACTIVE_H(AH), .FRONT_H(FH), .SYNC_H(SH), .BACK_H(BH),
    .ACTIVE_V(AV), .FRONT_V(FV), .SYNC_V(SV), .BACK_V(BV),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .PIPE_DELAY(DELAY_B), .COORD_W(10)
  ) dut_b (
    .clock(clock), .reset(reset), .enable(enable),
    .out_x(b_x), .out_y(b_y), .out_active(b_active), .out_line_start(b_line_start),
    .out_frame_start(b_frame_start), .out_hsync(b_hsync), .out_vsync(b_vsync),
    .out_de(b_de), .out_frame_start_d(b_frame_start_d)
  );

  typedef struct {
    int x;
    int y;
    bit act;
    bit ls;
    bit fs;
    bit hs;
    bit vs;
  } ref_t;

  int pos;       // enabled cycles since reset release
  int n_checks;
  int n_errors;

  // Raster state after p enabled cycles, straight from the line/frame layout.
  function automatic ref_t early_at(input int p);
    ref_t r;
    int   q;
    q     = p % FRAME;
    r.x   = q % TH;
    r.y   = q / TH;
    r.act = (r.x < AH) && (r.y < AV);
    r.ls  = (r.x == 0);
    r.fs  = (r.x == 0) && (r.y == 0);
    r.hs  = (r.x >= AH + FH) && (r.x < AH + FH + SH);
    r.vs  = (r.y >= AV + FV) && (r.y < AV + FV + SV);
    return r;
  endfunction

  function automatic ref_t delayed_at(input int p, input int d);
    ref_t r;
    if (p < d) begin
      r = early_at(0);
      r.act = 1'b0;
      r.fs  = 1'b0;
      r.hs  = 1'b0;
      r.vs  = 1'b0;
    end else begin
      r = early_at(p - d);
    end
    return r;
  endfunction

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s pos=%0d t=%0t got %0d expected %0d", tag, pos, $time, got, exp);
    end
  endtask

  task automatic compare_all();
    ref_t e, da, db;
    e  = early_at(pos);
    da = delayed_at(pos, DELAY_A);
    db = delayed_at(pos, DELAY_B);
    check("a_x", int'(a_x), e.x);
    check("a_y", int'(a_y), e.y);
    check("a_active", int'(a_active), int'(e.act));
    check("a_line_start", int'(a_line_start), int'(e.ls));
    check("a_frame_start", int'(a_frame_start), int'(e.fs));
    check("a_hsync", int'(a_hsync), int'(!da.hs));
    check("a_vsync", int'(a_vsync), int'(!da.vs));
    check("a_de", int'(a_de), int'(da.act));
    check("a_frame_start_d", int'(a_frame_start_d), int'(da.fs));
    check("b_x", int'(b_x), e.x);
    check("b_y", int'(b_y), e.y);
    check("b_active", int'(b_active), int'(e.act));
    check("b_line_start", int'(b_line_start), int'(e.ls));
    check("b_frame_start", int'(b_frame_start), int'(e.fs));
    check("b_hsync", int'(b_hsync), int'(db.hs));
    check("b_vsync", int'(b_vsync), int'(db.vs));
    check("b_de", int'(b_de), int'(db.act));
    check("b_frame_start_d", int'(b_frame_start_d), int'(db.fs));
  endtask

  task automatic step(input bit en);
    enable = en;
    @(posedge clock);
    if (en && reset) pos++;
    #1;
    compare_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int fs_pulses, de_count, vs_count, vs_first, fsd_first, guard;
    pos = 0;
    n_checks = 0;
    n_errors = 0;
    fs_pulses = 0;
    de_count = 0;
    vs_count = 0;
    vs_first = -1;
    fsd_first = -1;

    repeat (2) @(posedge clock);
    #1;
    compare_all();
    @(negedge clock);
    reset = 1'b1;

    // Free run: frame strobes, de per frame and vsync run length.
    if (a_frame_start) fs_pulses++;
    for (int i = 0; i < 100; i++) begin
      step(1'b1);
      if (a_frame_start) fs_pulses++;
      if (pos < FRAME) begin
        if (a_de) de_count++;
        if (!a_vsync) begin
          vs_count++;
          if (vs_first < 0) vs_first = pos;
        end
      end
    end
    check("frame_start_pulses", fs_pulses, 3);
    check("de_per_frame", de_count, 12);
    check("vsync_cycles", vs_count, 8);
    check("vsync_first_pos", vs_first, 4 * TH + DELAY_A);

    for (int i = 0; i < 200; i++) step($urandom_range(0, 3) != 0);

    // Stall at x=3, y=1.
    guard = 0;
    while (pos % FRAME != TH + 3 && guard < 2 * FRAME) begin
      step(1'b1);
      guard++;
    end
    check("reach_stall_point", pos % FRAME, TH + 3);
    repeat (5) step(1'b0);
    step(1'b1);
    check("resume_x", int'(a_x), 4);
    for (int i = 0; i < 10; i++) step(1'b1);

    // Asynchronous reset at x=6, y=4, between clock edges.
    guard = 0;
    while (pos % FRAME != 4 * TH + 6 && guard < 2 * FRAME) begin
      step(1'b1);
      guard++;
    end
    check("reach_reset_point", pos % FRAME, 4 * TH + 6);
    #2;
    reset = 1'b0;
    pos = 0;
    #1;
    compare_all();
    check("reset_vsync_idle", int'(a_vsync), 1);
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 60; i++) begin
      step(1'b1);
      if (a_frame_start_d && fsd_first < 0) fsd_first = pos;
    end
    check("frame_start_d_after_reset", fsd_first, DELAY_A);

    for (int i = 0; i < 100; i++) step($urandom_range(0, 1) != 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
